// File: rtl/fft_stage_sequencer.sv
// Run sequencer for one FFT: sample load, SIZE butterfly stages, bit-reversed readout.
// Every output is a flop decoded from the next state, so pulses align exactly with their state.
module fft_stage_sequencer #(
  parameter int N       = 16,
  parameter int SIZE    = 4,
  parameter int STG_W   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_fft,
  input  logic             load_done,
  input  logic             stage_done,
  input  logic             out_done,
  output logic             load_req,
  output logic             start_stage,
  output logic [STG_W-1:0] stage_idx,
  output logic             start_out,
  output logic             busy,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_STG_GO   = 3'd2,
    S_STG_WAIT = 3'd3,
    S_OUT_GO   = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Stage count never exceeds log2(N), so a mis-set SIZE cannot run past the data.
  localparam int STAGES = (SIZE < $clog2(N)) ? SIZE : $clog2(N);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(STAGES - 1);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam bit WD_EN = (TIMEOUT > 0);

  state_t           state_q, state_d;
  logic [STG_W-1:0] stage_idx_q, stage_idx_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_step;
  logic             wd_expired;
  logic             err_d;
  logic             load_req_q, start_stage_q, start_out_q, busy_q, done_q, err_q;

  assign wd_expired = WD_EN && (wd_q == WD_LAST);
  assign wd_step    = WD_EN ? (wd_q + WD_W'(1)) : '0;

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    wd_d        = wd_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_fft) begin
          state_d     = S_LOAD;
          stage_idx_d = '0;
          wd_d        = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // The awaited input is tested before expiry so it wins on the last cycle.
        if (load_done) begin
          state_d = S_STG_GO;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_step;
        end
      end
      S_STG_GO: begin
        state_d = S_STG_WAIT;
        wd_d    = '0;
      end
      S_STG_WAIT: begin
        if (stage_done) begin
          if (stage_idx_q == LAST_STG) begin
            state_d = S_OUT_GO;
          end else begin
            state_d     = S_STG_GO;
            stage_idx_d = stage_idx_q + STG_W'(1);
          end
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_step;
        end
      end
      S_OUT_GO: begin
        state_d = S_OUT_WAIT;
        wd_d    = '0;
      end
      S_OUT_WAIT: begin
        if (out_done) begin
          state_d = S_DONE;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_step;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        stage_idx_d = '0;
        wd_d        = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stage_idx_q   <= '0;
      wd_q          <= '0;
      load_req_q    <= 1'b0;
      start_stage_q <= 1'b0;
      start_out_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_idx_q   <= stage_idx_d;
      wd_q          <= wd_d;
      load_req_q    <= (state_d == S_LOAD);
      start_stage_q <= (state_d == S_STG_GO);
      start_out_q   <= (state_d == S_OUT_GO);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      err_q         <= err_d;
    end
  end

  assign load_req    = load_req_q;
  assign start_stage = start_stage_q;
  assign stage_idx   = stage_idx_q;
  assign start_out   = start_out_q;
  assign busy        = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
